digital_io_bank: RTL and testbench

- Parametrised multi-channel GPIO bank. Each channel has its own direction, a registered output driver, a 2-flop input synchroniser, a debounce filter and sticky rise/fall event flags.
- Combined interrupt output for the PLC core's input scan logic.
- Sits between the top-level bidirectional pads and the processor's I/O register file.
- Generalises the single-bit digital I/O cell to WIDTH channels, with input conditioning that the single-bit cell lacks.

---
 rtl/digital_io_bank.sv | 113 +++++++++++
 tb/tb_digital_io_bank.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_io_bank.sv
// digital_io_bank: WIDTH-channel GPIO bank.
//   Each channel has a registered output driver with its own direction bit, a
//   2-flop input synchroniser, a debounce filter and sticky rise/fall event flags.
//   Output channels read back their own pad value through the same input path.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   en        load enable for the direction and output registers
//   dir       per-channel direction (1 = drive, 0 = high-Z input)
//   data_in   values to drive on output channels
//   irq_en    per-channel interrupt enable
//   evt_clr   per-channel clear of both event flags
//   data_out  debounced pin state
//   rise_evt  sticky debounced 0->1 flag
//   fall_evt  sticky debounced 1->0 flag
//   irq       OR of enabled event flags
//   io_port   bidirectional pads
module digital_io_bank #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] dir,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_evt,
    output logic [WIDTH-1:0] fall_evt,
    output logic             irq,
    inout  wire  [WIDTH-1:0] io_port
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] out_q, dir_q;
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Output path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (en) begin
            out_q <= data_in;
            dir_q <= dir;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign io_port[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Debounce and event flags. Clear is applied first so a same-edge set wins.
    always_comb begin
        deb_d  = deb_q;
        rise_d = rise_q & ~evt_clr;
        fall_d = fall_q & ~evt_clr;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    deb_d[i] = s2_q[i];
                    if (s2_q[i]) begin
                        rise_d[i] = 1'b1;
                    end else begin
                        fall_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Input path is free-running, independent of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= io_port;
            s2_q   <= s1_q;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign data_out = deb_q;
    assign rise_evt = rise_q;
    assign fall_evt = fall_q;
    assign irq      = |((rise_q | fall_q) & irq_en);

endmodule

// File: tb/tb_digital_io_bank.sv
module tb_digital_io_bank;

    localparam int W   = 8;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en;
    logic [W-1:0] dir, data_in, irq_en, evt_clr;
    logic [W-1:0] data_out, rise_evt, fall_evt;
    logic         irq;
    wire  [W-1:0] io_port;
    logic [W-1:0] tb_val;

    int total = 0;
    int bad   = 0;

    digital_io_bank #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .data_in  (data_in),
        .irq_en   (irq_en),
        .evt_clr  (evt_clr),
        .data_out (data_out),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt),
        .irq      (irq),
        .io_port  (io_port)
    );

    always #5 clk = ~clk;

    // Reference model: the filtered value flips once the DEB most recent synchronised
    // samples all disagree with it. m_smp[k] is the pad value seen k+1 edges ago.
    logic [W-1:0] m_dir, m_out, m_deb, m_rise, m_fall, m_pad, m_flip;
    logic [W-1:0] m_smp [0:DEB];
    logic         m_irq;

    // Bench drives a pad only when the model says the DUT does not
    for (genvar i = 0; i < W; i++) begin : g_drv
        assign io_port[i] = m_dir[i] ? 1'bz : tb_val[i];
    end

    always_comb begin
        m_pad = (m_dir & m_out) | (~m_dir & tb_val);
        for (int c = 0; c < W; c++) begin
            m_flip[c] = 1'b1;
            for (int k = 1; k <= DEB; k++) begin
                if (m_smp[k][c] == m_deb[c]) m_flip[c] = 1'b0;
            end
        end
        m_irq = |((m_rise | m_fall) & irq_en);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dir  <= '0;
            m_out  <= '0;
            m_deb  <= '0;
            m_rise <= '0;
            m_fall <= '0;
            for (int k = 0; k <= DEB; k++) m_smp[k] <= '0;
        end else begin
            if (en) begin
                m_dir <= dir;
                m_out <= data_in;
            end
            m_deb  <= m_deb ^ m_flip;
            m_rise <= (m_rise & ~evt_clr) | (m_flip & ~m_deb);
            m_fall <= (m_fall & ~evt_clr) | (m_flip & m_deb);
            m_smp[0] <= m_pad;
            for (int k = 1; k <= DEB; k++) m_smp[k] <= m_smp[k-1];
        end
    end

    logic [4*W:0] act_vec, exp_vec;
    assign act_vec = {data_out, rise_evt, fall_evt, irq, io_port};
    assign exp_vec = {m_deb, m_rise, m_fall, m_irq, m_pad};

    // Stimulus-only waits
    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all();
        evt_clr = '1;
        @(negedge clk);
        evt_clr = '0;
    endtask

    task automatic test_reset();
        en = 0; dir = '0; data_in = '0; irq_en = '0; evt_clr = '0; tb_val = '0;
        #1 rst_n = 1'b0;
        settle(2);
        total++;
        if ({data_out, rise_evt, fall_evt, irq} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {data_out, rise_evt, fall_evt, irq});
        end
        total++;
        if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL reset_model: got %h want %h", act_vec, exp_vec);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_output();
        en = 1; dir = 8'hF0; data_in = 8'hA5; tb_val = W'($urandom);
        @(negedge clk);
        en = 0;
        for (int k = 0; k < 4; k++) begin
            data_in = W'($urandom);
            @(negedge clk);
            total++;
            if (io_port[7:4] !== 4'hA || act_vec !== exp_vec) begin
                bad++;
                $display("FAIL output_hold: got pads %h vec %h want pads a vec %h",
                         io_port[7:4], act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_rise_ch0();
        tb_val[0] = 1'b0;
        settle(8);
        clear_all();
        irq_en = '0;
        tb_val[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (data_out[0] !== (k >= 6) || rise_evt[0] !== (k >= 6) || act_vec !== exp_vec) begin
                bad++;
                $display("FAIL rise_ch0 k=%0d: got deb %b rise %b vec %h want %b vec %h",
                         k, data_out[0], rise_evt[0], act_vec, (k >= 6), exp_vec);
            end
            if (k == 6) begin
                total++;
                if (irq !== 1'b0) begin
                    bad++;
                    $display("FAIL irq_masked: got %b want 0", irq);
                end
                irq_en = 8'h01;
                #1;
                total++;
                if (irq !== 1'b1) begin
                    bad++;
                    $display("FAIL irq_enabled: got %b want 1", irq);
                end
            end
        end
    endtask

    task automatic test_pulse();
        tb_val[1] = 1'b0;
        settle(8);
        clear_all();
        for (int k = 0; k < 12; k++) begin
            tb_val[1] = (k < 3);
            @(negedge clk);
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL pulse3 k=%0d: got %h want %h", k, act_vec, exp_vec);
            end
        end
        total++;
        if ({data_out[1], rise_evt[1], fall_evt[1]} !== 3'b000) begin
            bad++;
            $display("FAIL pulse3_filtered: got %b want 000",
                     {data_out[1], rise_evt[1], fall_evt[1]});
        end
        for (int k = 0; k < 16; k++) begin
            tb_val[1] = (k < 4);
            @(negedge clk);
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL pulse4 k=%0d: got %h want %h", k, act_vec, exp_vec);
            end
        end
        total++;
        if ({data_out[1], rise_evt[1], fall_evt[1]} !== 3'b011) begin
            bad++;
            $display("FAIL pulse4_events: got %b want 011",
                     {data_out[1], rise_evt[1], fall_evt[1]});
        end
    endtask

    task automatic test_clr_collision();
        tb_val[2] = 1'b1;
        settle(8);
        tb_val[2] = 1'b0;
        settle(8);
        tb_val[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL collide k=%0d: got %h want %h", k, act_vec, exp_vec);
            end
            if (k == 5) evt_clr = 8'h04;
            if (k == 6) evt_clr = 8'h00;
        end
        total++;
        if ({data_out[2], rise_evt[2], fall_evt[2]} !== 3'b110) begin
            bad++;
            $display("FAIL set_beats_clr: got %b want 110",
                     {data_out[2], rise_evt[2], fall_evt[2]});
        end
        irq_en = 8'h04;
        #1;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_ch2_set: got %b want 1", irq);
        end
        evt_clr = 8'h04;
        @(negedge clk);
        evt_clr = 8'h00;
        total++;
        if (rise_evt[2] !== 1'b0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL clr_alone: got rise %b irq %b want 0 0", rise_evt[2], irq);
        end
    endtask

    task automatic test_reset_mid();
        tb_val[3] = 1'b0;
        settle(8);
        tb_val[3] = 1'b1;
        settle(4);
        rst_n = 1'b0;
        #1;
        total++;
        if ({data_out, rise_evt, fall_evt, irq} !== '0 || act_vec !== exp_vec) begin
            bad++;
            $display("FAIL reset_mid: got %h want %h", act_vec, exp_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (data_out[3] !== (k >= 6) || rise_evt[3] !== (k >= 6) || act_vec !== exp_vec) begin
                bad++;
                $display("FAIL post_reset_rise k=%0d: got deb %b rise %b want %b",
                         k, data_out[3], rise_evt[3], (k >= 6));
            end
        end
    endtask

    task automatic test_output_toggle();
        en = 1; dir = 8'hF0; data_in = '0;
        settle(10);
        clear_all();
        for (int t = 0; t < 4; t++) begin
            data_in = W'($urandom);
            data_in[4] = (t % 2 == 0);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                total++;
                if (act_vec !== exp_vec) begin
                    bad++;
                    $display("FAIL toggle t=%0d k=%0d: got %h want %h", t, k, act_vec, exp_vec);
                end
            end
            total++;
            if (data_out[4] !== data_in[4] ||
                (data_in[4] ? rise_evt[4] : fall_evt[4]) !== 1'b1) begin
                bad++;
                $display("FAIL toggle_readback t=%0d: got deb %b rise %b fall %b want deb %b",
                         t, data_out[4], rise_evt[4], fall_evt[4], data_in[4]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en      = ($urandom_range(0, 3) == 0);
            dir     = W'($urandom);
            data_in = W'($urandom);
            tb_val  = tb_val ^ (W'($urandom) & W'($urandom) & W'($urandom));
            evt_clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) irq_en = W'($urandom);
            @(negedge clk);
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL random k=%0d: got %h want %h", k, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_output();
        test_rise_ch0();
        test_pulse();
        test_clr_collision();
        test_reset_mid();
        test_output_toggle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
